// File: rtl/generic_fifo.sv
// generic_fifo: parametrised single-clock FIFO with storage, pointer control,
// occupancy count, almost-full/almost-empty thresholds and sticky error flags.
// Supports a registered read (one-cycle latency) or first-word-fall-through.
module generic_fifo #(
    parameter int WIDTH    = 64,
    parameter int DEPTH    = 4,
    parameter int AF_LEVEL = DEPTH - 1,
    parameter int AE_LEVEL = 1,
    parameter bit FWFT     = 1'b0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     rd_valid,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow,
    input  logic                     clr_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [CW-1:0] ONE     = CW'(1);
    localparam logic [CW-1:0] ZERO    = '0;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

    // Storage is deliberately left unreset; pointers alone define validity.
    logic [WIDTH-1:0] mem [DEPTH];

    // Pointers carry one extra wrap bit above the address bits.
    logic [CW-1:0]    wr_ptr;
    logic [CW-1:0]    rd_ptr;
    logic [CW-1:0]    count_nxt;
    logic             pop_ok;
    logic             push_ok;
    logic [WIDTH-1:0] head;

    assign head = mem[rd_ptr[AW-1:0]];

    // Acceptance: a pop frees a slot for a simultaneous push when full, but a
    // push into an empty FIFO is never bypassed straight to the pop side.
    always_comb begin
        pop_ok    = pop & ~empty;
        push_ok   = push & (~full | pop_ok);
        count_nxt = count;
        if (push_ok && !pop_ok) begin
            count_nxt = count + ONE;
        end else if (pop_ok && !push_ok) begin
            count_nxt = count - ONE;
        end
    end

    // Write accepted data into the slot addressed by the write pointer.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
        end
    end

    // Pointers, occupancy and status flags; flags derive from the next count
    // so they always agree with count in the same cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + ONE;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + ONE;
            end
            count        <= count_nxt;
            full         <= (count_nxt == DEPTH_C);
            empty        <= (count_nxt == ZERO);
            almost_full  <= (count_nxt >= AF_C);
            almost_empty <= (count_nxt <= AE_C);
        end
    end

    // Sticky error flags; a fresh error in the clearing cycle keeps the flag set.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= (overflow & ~clr_err) | (push & ~push_ok);
            underflow <= (underflow & ~clr_err) | (pop & empty);
        end
    end

    generate
        if (FWFT) begin : g_fwft
            // Head word is shown as soon as the FIFO is non-empty; zero when empty.
            assign rd_data  = empty ? '0 : head;
            assign rd_valid = ~empty;
        end else begin : g_reg
            logic [WIDTH-1:0] rd_data_q;
            logic             rd_valid_q;

            // Registered read: popped word appears after the accepting edge for one cycle.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    rd_data_q  <= '0;
                    rd_valid_q <= 1'b0;
                end else begin
                    rd_valid_q <= pop_ok;
                    if (pop_ok) begin
                        rd_data_q <= head;
                    end
                end
            end

            assign rd_data  = rd_data_q;
            assign rd_valid = rd_valid_q;
        end
    endgenerate

endmodule

// File: tb/tb_generic_fifo.sv
// tb_generic_fifo: directed bench for generic_fifo with a queue scoreboard.
// Three instances: 4x64 registered read, 4x64 FWFT, 16x8 with custom thresholds.
module tb_generic_fifo;

    logic clk;
    logic reset;
    logic reset_c;

    // Instance A: WIDTH=64 DEPTH=4 FWFT=0
    logic        push_a, pop_a, clr_a;
    logic [63:0] wr_data_a, rd_data_a;
    logic        rd_valid_a, full_a, empty_a, af_a, ae_a, ovf_a, unf_a;
    logic [2:0]  count_a;

    // Instance B: WIDTH=64 DEPTH=4 FWFT=1
    logic        push_b, pop_b, clr_b;
    logic [63:0] wr_data_b, rd_data_b;
    logic        rd_valid_b, full_b, empty_b, af_b, ae_b, ovf_b, unf_b;
    logic [2:0]  count_b;

    // Instance C: WIDTH=8 DEPTH=16 AF=12 AE=2 FWFT=0
    logic        push_c, pop_c, clr_c;
    logic [7:0]  wr_data_c, rd_data_c;
    logic        rd_valid_c, full_c, empty_c, af_c, ae_c, ovf_c, unf_c;
    logic [4:0]  count_c;

    int n_vec = 0;
    int n_bad = 0;

    logic [63:0] q_a[$];
    logic [63:0] q_b[$];
    logic [63:0] q_c[$];

    generic_fifo #(.WIDTH(64), .DEPTH(4), .FWFT(1'b0)) u_a (
        .clk(clk), .reset(reset), .push(push_a), .wr_data(wr_data_a), .pop(pop_a),
        .rd_data(rd_data_a), .rd_valid(rd_valid_a), .full(full_a), .empty(empty_a),
        .almost_full(af_a), .almost_empty(ae_a), .count(count_a),
        .overflow(ovf_a), .underflow(unf_a), .clr_err(clr_a));

    generic_fifo #(.WIDTH(64), .DEPTH(4), .FWFT(1'b1)) u_b (
        .clk(clk), .reset(reset), .push(push_b), .wr_data(wr_data_b), .pop(pop_b),
        .rd_data(rd_data_b), .rd_valid(rd_valid_b), .full(full_b), .empty(empty_b),
        .almost_full(af_b), .almost_empty(ae_b), .count(count_b),
        .overflow(ovf_b), .underflow(unf_b), .clr_err(clr_b));

    generic_fifo #(.WIDTH(8), .DEPTH(16), .AF_LEVEL(12), .AE_LEVEL(2), .FWFT(1'b0)) u_c (
        .clk(clk), .reset(reset_c), .push(push_c), .wr_data(wr_data_c), .pop(pop_c),
        .rd_data(rd_data_c), .rd_valid(rd_valid_c), .full(full_c), .empty(empty_c),
        .almost_full(af_c), .almost_empty(ae_c), .count(count_c),
        .overflow(ovf_c), .underflow(unf_c), .clr_err(clr_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic unexpected(input string name);
        n_vec++;
        n_bad++;
        $display("FAIL %s: output valid with no expected word at %0t", name, $time);
    endtask

    // Monitors: pop expected words whenever a DUT presents read data.
    always @(negedge clk) begin
        if (rd_valid_a === 1'b1) begin
            if (q_a.size() == 0) unexpected("rd_a");
            else check("rd_a", rd_data_a, q_a.pop_front());
        end
    end

    always @(negedge clk) begin
        if (pop_b === 1'b1 && q_b.size() != 0) begin
            check("rd_valid_b", {63'd0, rd_valid_b}, 64'd1);
            check("rd_b", rd_data_b, q_b.pop_front());
        end
    end

    always @(negedge clk) begin
        if (rd_valid_c === 1'b1) begin
            if (q_c.size() == 0) unexpected("rd_c");
            else check("rd_c", {56'd0, rd_data_c}, q_c.pop_front());
        end
    end

    task automatic cyc_a(input logic p, input logic [63:0] d, input logic q, input logic c);
        push_a = p; wr_data_a = d; pop_a = q; clr_a = c;
        @(posedge clk); #1;
        push_a = 1'b0; pop_a = 1'b0; clr_a = 1'b0;
    endtask

    task automatic cyc_b(input logic p, input logic [63:0] d, input logic q);
        push_b = p; wr_data_b = d; pop_b = q;
        @(posedge clk); #1;
        push_b = 1'b0; pop_b = 1'b0;
    endtask

    task automatic cyc_c(input logic p, input logic [7:0] d, input logic q);
        push_c = p; wr_data_c = d; pop_c = q;
        @(posedge clk); #1;
        push_c = 1'b0; pop_c = 1'b0;
    endtask

    initial begin
        reset = 1'b0; reset_c = 1'b0;
        push_a = 0; pop_a = 0; clr_a = 0; wr_data_a = '0;
        push_b = 0; pop_b = 0; clr_b = 0; wr_data_b = '0;
        push_c = 0; pop_c = 0; clr_c = 0; wr_data_c = '0;
        repeat (2) @(posedge clk);
        #1;

        // Reset state
        check("rst_count",   {61'd0, count_a}, 64'd0);
        check("rst_empty",   {63'd0, empty_a}, 64'd1);
        check("rst_ae",      {63'd0, ae_a}, 64'd1);
        check("rst_full",    {63'd0, full_a}, 64'd0);
        check("rst_af",      {63'd0, af_a}, 64'd0);
        check("rst_rdvalid", {63'd0, rd_valid_a}, 64'd0);
        check("rst_rddata",  rd_data_a, 64'd0);
        check("rst_ovf",     {63'd0, ovf_a}, 64'd0);
        check("rst_unf",     {63'd0, unf_a}, 64'd0);
        check("rst_b_valid", {63'd0, rd_valid_b}, 64'd0);
        reset = 1'b1; reset_c = 1'b1;
        cyc_a(0, 0, 0, 0);

        // 1: fill with A0..A3, then drain in order
        for (int i = 0; i < 4; i++) cyc_a(1, 64'hA0 + 64'(i), 0, 0);
        check("t1_full",  {63'd0, full_a}, 64'd1);
        check("t1_count", {61'd0, count_a}, 64'd4);
        check("t1_af",    {63'd0, af_a}, 64'd1);
        check("t1_empty", {63'd0, empty_a}, 64'd0);
        for (int i = 0; i < 4; i++) begin
            q_a.push_back(64'hA0 + 64'(i));
            cyc_a(0, 0, 1, 0);
        end
        cyc_a(0, 0, 0, 0);
        check("t1_empty_end", {63'd0, empty_a}, 64'd1);
        check("t1_count_end", {61'd0, count_a}, 64'd0);

        // 2: overflow on fifth push; 0xFF must never be read
        for (int i = 0; i < 4; i++) cyc_a(1, 64'hC0 + 64'(i), 0, 0);
        cyc_a(1, 64'hFF, 0, 0);
        check("t2_ovf",   {63'd0, ovf_a}, 64'd1);
        check("t2_count", {61'd0, count_a}, 64'd4);
        cyc_a(0, 0, 0, 1);
        check("t2_clr",   {63'd0, ovf_a}, 64'd0);

        // 3: full with simultaneous push+pop for 10 cycles
        for (int i = 0; i < 10; i++) begin
            if (i < 4) q_a.push_back(64'hC0 + 64'(i));
            else       q_a.push_back(64'hB0 + 64'(i - 4));
            cyc_a(1, 64'hB0 + 64'(i), 1, 0);
        end
        check("t3_count", {61'd0, count_a}, 64'd4);
        check("t3_full",  {63'd0, full_a}, 64'd1);
        check("t3_ovf",   {63'd0, ovf_a}, 64'd0);
        for (int i = 6; i < 10; i++) begin
            q_a.push_back(64'hB0 + 64'(i));
            cyc_a(0, 0, 1, 0);
        end
        cyc_a(0, 0, 0, 0);
        check("t3_empty", {63'd0, empty_a}, 64'd1);

        // 4: underflow, clear, new error in clear cycle, push+pop on empty
        cyc_a(0, 0, 1, 0);
        check("t4_unf",     {63'd0, unf_a}, 64'd1);
        check("t4_rdvalid", {63'd0, rd_valid_a}, 64'd0);
        cyc_a(0, 0, 0, 1);
        check("t4_clr",     {63'd0, unf_a}, 64'd0);
        cyc_a(0, 0, 1, 1);
        check("t4_clr_win", {63'd0, unf_a}, 64'd1);
        cyc_a(0, 0, 0, 1);
        cyc_a(1, 64'hD0, 1, 0);
        check("t4_pp_count", {61'd0, count_a}, 64'd1);
        check("t4_pp_unf",   {63'd0, unf_a}, 64'd1);
        check("t4_pp_empty", {63'd0, empty_a}, 64'd0);
        q_a.push_back(64'hD0);
        cyc_a(0, 0, 1, 0);
        cyc_a(0, 0, 0, 0);
        check("t4_empty", {63'd0, empty_a}, 64'd1);

        // 5: FWFT head visible without pop
        cyc_b(1, 64'h55, 0);
        check("t5_valid", {63'd0, rd_valid_b}, 64'd1);
        check("t5_data",  rd_data_b, 64'h55);
        check("t5_count", {61'd0, count_b}, 64'd1);
        cyc_b(0, 0, 0);
        check("t5_hold",  rd_data_b, 64'h55);
        q_b.push_back(64'h55);
        cyc_b(0, 0, 1);
        check("t5_empty", {63'd0, empty_b}, 64'd1);
        check("t5_novalid", {63'd0, rd_valid_b}, 64'd0);

        // 6: 16-deep thresholds across a full fill
        for (int i = 0; i <= 16; i++) begin
            check("t6_count", {59'd0, count_c}, 64'(i));
            check("t6_ae",    {63'd0, ae_c}, (i <= 2) ? 64'd1 : 64'd0);
            check("t6_af",    {63'd0, af_c}, (i >= 12) ? 64'd1 : 64'd0);
            check("t6_full",  {63'd0, full_c}, (i == 16) ? 64'd1 : 64'd0);
            check("t6_empty", {63'd0, empty_c}, (i == 0) ? 64'd1 : 64'd0);
            if (i < 16) cyc_c(1, 8'(i), 0);
        end
        for (int i = 0; i < 7; i++) begin
            q_c.push_back(64'(i));
            cyc_c(0, 0, 1);
        end
        cyc_c(0, 0, 0);
        check("t6_count9", {59'd0, count_c}, 64'd9);
        #1 reset_c = 1'b0;
        #1;
        check("t6_rst_count", {59'd0, count_c}, 64'd0);
        check("t6_rst_empty", {63'd0, empty_c}, 64'd1);
        check("t6_rst_ae",    {63'd0, ae_c}, 64'd1);
        check("t6_rst_af",    {63'd0, af_c}, 64'd0);
        check("t6_rst_full",  {63'd0, full_c}, 64'd0);
        check("t6_rst_valid", {63'd0, rd_valid_c}, 64'd0);
        check("t6_rst_data",  {56'd0, rd_data_c}, 64'd0);
        check("t6_rst_err",   {62'd0, ovf_c, unf_c}, 64'd0);
        @(posedge clk); #1;
        reset_c = 1'b1;
        cyc_c(0, 0, 0);
        check("t6_after_rst", {59'd0, count_c}, 64'd0);

        check("q_a_drained", 64'(q_a.size()), 64'd0);
        check("q_b_drained", 64'(q_b.size()), 64'd0);
        check("q_c_drained", 64'(q_c.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
